// File: rtl/serial_subtractor_nbit.sv
// Digit-serial N-bit subtractor: computes a - b, D bits per clock, LSB digit first,
// behind a start/busy/done handshake with borrow, overflow and zero flags.
module serial_subtractor_nbit #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         b_out,
    output logic         ovf,
    output logic         zero
);

    localparam int DIGITS = N / D;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
        $error("serial_subtractor_nbit: N must be >= 2 and a multiple of D (1 <= D <= N)");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [N-1:0]     d_reg;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic [D-1:0]     diff_digit;
    logic             borrow_next;
    logic [N+D-1:0]   shift_tmp;
    logic [N-1:0]     d_shifted;
    logic             last_digit;

    // One D-bit slice: bit D of the (D+1)-bit result is the borrow out.
    function automatic logic [D:0] sub_digit(input logic [D-1:0] x,
                                             input logic [D-1:0] y,
                                             input logic         bin);
        return {1'b0, x} - {1'b0, y} - {{D{1'b0}}, bin};
    endfunction

    function automatic logic sub_overflow(input logic a_sign,
                                          input logic b_sign,
                                          input logic r_sign);
        return (a_sign != b_sign) && (r_sign != a_sign);
    endfunction

    always_comb begin
        {borrow_next, diff_digit} = sub_digit(a_reg[D-1:0], b_reg[D-1:0], borrow);
        shift_tmp  = {diff_digit, d_reg} >> D;
        d_shifted  = shift_tmp[N-1:0];
        last_digit = (cnt == LAST_DIGIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so no output is a decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            d_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_reg  <= a_reg >> D;
                    b_reg  <= b_reg >> D;
                    d_reg  <= d_shifted;
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    // Flags are taken from the fully assembled result on the last digit.
                    if (last_digit) begin
                        b_out <= borrow_next;
                        ovf   <= sub_overflow(a_msb, b_msb, d_shifted[N-1]);
                        zero  <= (d_shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign d = d_reg;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Bench for serial_subtractor_nbit: directed vectors, handshake corner cases and
// randomized operands on three parameterisations against an arithmetic reference.
module tb_serial_subtractor_nbit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: N=16, D=4
    logic        st16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, d16;
    logic        busy16, done16, bo16, ov16, z16;
    // Instance 1: N=8, D=1
    logic        st8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, d8;
    logic        busy8, done8, bo8, ov8, z8;
    // Instance 2: N=34, D=34
    logic        st34 = 1'b0;
    logic [33:0] a34 = '0, b34 = '0, d34;
    logic        busy34, done34, bo34, ov34, z34;

    serial_subtractor_nbit #(.N(16), .D(4)) u_n16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .d(d16), .b_out(bo16), .ovf(ov16), .zero(z16)
    );
    serial_subtractor_nbit #(.N(8), .D(1)) u_n8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .b_out(bo8), .ovf(ov8), .zero(z8)
    );
    serial_subtractor_nbit #(.N(34), .D(34)) u_n34 (
        .clk(clk), .rst_n(rst_n), .start(st34), .a(a34), .b(b34),
        .busy(busy34), .done(done34), .d(d34), .b_out(bo34), .ovf(ov34), .zero(z34)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int width_of  [3] = '{16, 8, 34};
    int digits_of [3] = '{4, 8, 1};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain modular/signed arithmetic on the whole operands.
    function automatic void model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] dv, output logic bo, output logic ov,
                                  output logic z);
        logic [63:0] mask, am, bm;
        longint sa, sb, df, mx, mn;
        mask = (64'd1 << n) - 64'd1;
        am = av & mask;
        bm = bv & mask;
        dv = (am - bm) & mask;
        bo = (am < bm);
        sa = longint'(am);
        sb = longint'(bm);
        if (am[n-1]) sa = sa - (longint'(1) <<< n);
        if (bm[n-1]) sb = sb - (longint'(1) <<< n);
        df = sa - sb;
        mx = (longint'(1) <<< (n - 1)) - 1;
        mn = -(longint'(1) <<< (n - 1));
        ov = (df > mx) || (df < mn);
        z  = (dv == 64'd0);
    endfunction

    task automatic drive(input int inst, input logic s, input logic [63:0] av, input logic [63:0] bv);
        case (inst)
            0:       begin st16 = s; a16 = av[15:0]; b16 = bv[15:0]; end
            1:       begin st8  = s; a8  = av[7:0];  b8  = bv[7:0];  end
            default: begin st34 = s; a34 = av[33:0]; b34 = bv[33:0]; end
        endcase
    endtask

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return busy16;
            1:       return busy8;
            default: return busy34;
        endcase
    endfunction

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return done16;
            1:       return done8;
            default: return done34;
        endcase
    endfunction

    task automatic read_out(input int inst, output logic [63:0] dv, output logic bo,
                            output logic ov, output logic z);
        case (inst)
            0:       begin dv = 64'(d16); bo = bo16; ov = ov16; z = z16; end
            1:       begin dv = 64'(d8);  bo = bo8;  ov = ov8;  z = z8;  end
            default: begin dv = 64'(d34); bo = bo34; ov = ov34; z = z34; end
        endcase
    endtask

    // Starts from idle, returns results at the done cycle plus timing observations.
    task automatic run_op(input int inst, input logic [63:0] av, input logic [63:0] bv,
                          output logic ok, output logic [63:0] dv, output logic bo,
                          output logic ov, output logic z, output int lat, output int bc,
                          output logic busy_after);
        int k;
        ok = 1'b0; lat = 0; bc = 0; k = 0;
        dv = '0; bo = 1'b0; ov = 1'b0; z = 1'b0;
        @(negedge clk);
        drive(inst, 1'b1, av, bv);
        @(posedge clk);
        @(negedge clk);
        drive(inst, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 64 && !ok; i++) begin
            if (i > 0) @(negedge clk);
            k++;
            if (busy_of(inst)) bc++;
            if (done_of(inst)) begin
                ok  = 1'b1;
                lat = k - 1;
                read_out(inst, dv, bo, ov, z);
            end
        end
        @(negedge clk);
        busy_after = busy_of(inst);
    endtask

    task automatic check_op(input int inst, input string tag, input logic [63:0] av,
                            input logic [63:0] bv, input logic chk_busy);
        logic ok, bo, ov, z, ba, ebo, eov, ez;
        logic [63:0] dv, edv;
        int lat, bc;
        run_op(inst, av, bv, ok, dv, bo, ov, z, lat, bc, ba);
        model(width_of[inst], av, bv, edv, ebo, eov, ez);
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        if (ok) begin
            check({tag, "_d"},     dv,            edv);
            check({tag, "_b_out"}, 64'(bo),       64'(ebo));
            check({tag, "_ovf"},   64'(ov),       64'(eov));
            check({tag, "_zero"},  64'(z),        64'(ez));
            check({tag, "_lat"},   64'(lat),      64'(digits_of[inst]));
            check({tag, "_idle"},  64'(ba),       64'd0);
            if (chk_busy) check({tag, "_busy_cycles"}, 64'(bc), 64'(digits_of[inst] + 1));
        end
    endtask

    initial begin
        vec_t vt[6];
        logic [63:0] dv, edv;
        logic bo, ov, z, ebo, eov, ez, seen_done;
        logic [15:0] ha[32], hb[32];
        int ndone, last_done;

        vt[0] = '{a: 16'h1234, b: 16'h0234, d: 16'h1000, bo: 1'b0, ov: 1'b0, z: 1'b0};
        vt[1] = '{a: 16'h0000, b: 16'h0001, d: 16'hFFFF, bo: 1'b1, ov: 1'b0, z: 1'b0};
        vt[2] = '{a: 16'h8000, b: 16'h0001, d: 16'h7FFF, bo: 1'b0, ov: 1'b1, z: 1'b0};
        vt[3] = '{a: 16'h7FFF, b: 16'hFFFF, d: 16'h8000, bo: 1'b1, ov: 1'b1, z: 1'b0};
        vt[4] = '{a: 16'hA5A5, b: 16'hA5A5, d: 16'h0000, bo: 1'b0, ov: 1'b0, z: 1'b1};
        vt[5] = '{a: 16'hFFFF, b: 16'h0000, d: 16'hFFFF, bo: 1'b0, ov: 1'b0, z: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_done16", 64'(done16), 64'd0);
        check("rst_d16",    64'(d16),    64'd0);
        check("rst_flags16", 64'({bo16, ov16, z16}), 64'd0);
        check("rst_d34",    64'(d34),    64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            logic ok, ba;
            int lat, bc;
            run_op(0, 64'(vt[i].a), 64'(vt[i].b), ok, dv, bo, ov, z, lat, bc, ba);
            check($sformatf("vec%0d_done_seen", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d_d", i),    dv,      64'(vt[i].d));
            check($sformatf("vec%0d_b_out", i), 64'(bo), 64'(vt[i].bo));
            check($sformatf("vec%0d_ovf", i),  64'(ov),  64'(vt[i].ov));
            check($sformatf("vec%0d_zero", i), 64'(z),   64'(vt[i].z));
            check($sformatf("vec%0d_lat", i),  64'(lat), 64'd4);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd5);
            check($sformatf("vec%0d_idle", i), 64'(ba),  64'd0);
            check($sformatf("vec%0d_hold_d", i), 64'(d16), 64'(vt[i].d));
        end

        // Start held high with changing operands: only accepting-edge operands matter
        ndone = 0; last_done = -100;
        for (int e = 0; e < 28; e++) begin
            ha[e] = 16'($urandom);
            hb[e] = 16'($urandom);
            st16 = (e < 20); a16 = ha[e]; b16 = hb[e];
            @(posedge clk);
            @(negedge clk);
            if (done16) begin
                ndone++;
                check("hold_phase", 64'(e % 6), 64'd4);
                if (last_done >= 0) check("hold_spacing", 64'(e - last_done), 64'd6);
                last_done = e;
                if (e >= 4) begin
                    model(16, 64'(ha[e-4]), 64'(hb[e-4]), edv, ebo, eov, ez);
                    check("hold_d", 64'(d16), edv);
                    check("hold_flags", 64'({bo16, ov16, z16}), 64'({ebo, eov, ez}));
                end
            end
        end
        check("hold_accepts", 64'(ndone), 64'd4);
        st16 = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset two edges after accept
        drive(0, 1'b1, 64'h0010, 64'h0001);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy16), 64'd0);
        check("arst_done", 64'(done16), 64'd0);
        check("arst_d",    64'(d16),    64'd0);
        check("arst_flags", 64'({bo16, ov16, z16}), 64'd0);
        seen_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done16) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done16 || busy16) seen_done = 1'b1;
        end
        check("arst_no_done", 64'(seen_done), 64'd0);
        check_op(0, "post_rst", 64'h0010, 64'h0001, 1'b1);
        check("post_rst_d_const", 64'(d16), 64'h000F);

        // Randomized operands on all three parameterisations
        for (int i = 0; i < 200; i++) check_op(0, "rnd16", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 1000; i++) check_op(1, "rnd8", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 1000; i++) check_op(2, "rnd34", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        // Edge operands for the wide single-digit case
        check_op(2, "n34_min", 64'h0, 64'h1, 1'b1);
        check_op(2, "n34_ovf", 64'h2_0000_0000, 64'h1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
